// File: rtl/bcd_pkg.sv
// Shared types and helpers for the binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DIGITS_DEFAULT = 8;

  // Largest value representable in 'digits' decimal digits (10^digits - 1).
  function automatic longint unsigned max_val(input int digits);
    longint unsigned p;
    p = 64'd1;
    for (int i = 0; i < digits; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bcd_adjust.sv
// Double-dabble correction: every BCD nibble >= 5 gets +3 so the following
// left shift carries correctly into the next decimal digit.
module bcd_adjust
  import bcd_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic [4*DIGITS-1:0] din,
  output logic [4*DIGITS-1:0] dout
);

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nibble
    logic [3:0] nib;
    assign nib = din[4*gi +: 4];
    assign dout[4*gi +: 4] = (nib >= 4'd5) ? 4'(nib + 4'd3) : nib;
  end

endmodule

// File: rtl/bin2bcd8.sv
// Sequential binary-to-BCD converter (shift-add-3) with a one-deep pending
// buffer so the producer never stalls. bcd_out only changes on completion.
module bin2bcd8
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [WIDTH-1:0]    bin,
  output logic [4*DIGITS-1:0] bcd_out,
  output logic                sat,
  output logic                done,
  output logic                busy
);

  localparam int              BW       = 4 * DIGITS;
  localparam int              CW       = $clog2(WIDTH + 1);
  localparam longint unsigned MAX_L    = max_val(DIGITS);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  work_q, work_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sat_flag_q, sat_flag_d;
  logic              pend_q, pend_d;
  logic [WIDTH-1:0]  pend_val_q, pend_val_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              sat_q, sat_d;
  logic              done_q, done_d;

  logic [BW-1:0]       scratch_adj;
  logic [BW+WIDTH-1:0] shifted;
  logic [WIDTH-1:0]    start_val;
  logic                start_over;
  logic [WIDTH-1:0]    start_work;
  logic                start;

  bcd_adjust #(
    .DIGITS (DIGITS)
  ) u_adjust (
    .din  (scratch_q),
    .dout (scratch_adj)
  );

  assign shifted = {scratch_adj, work_q} << 1;

  // Select the value to start next (fresh input beats pending) and clamp it.
  always_comb begin
    start_val  = (state_q == IDLE || in_valid) ? bin : pend_val_q;
    start_over = 64'(start_val) > MAX_L;
    start_work = start_over ? WIDTH'(MAX_L) : start_val;
  end

  // Next-state, datapath and result update logic.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    sat_flag_d = sat_flag_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    bcd_d      = bcd_q;
    sat_d      = sat_q;
    done_d     = 1'b0;
    start      = 1'b0;

    case (state_q)
      IDLE: begin
        start = in_valid;
      end
      SHIFT: begin
        scratch_d = shifted[BW+WIDTH-1:WIDTH];
        work_d    = shifted[WIDTH-1:0];
        cnt_d     = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          // Final shift: publish the result and chain into the next value.
          bcd_d  = shifted[BW+WIDTH-1:WIDTH];
          sat_d  = sat_flag_q;
          done_d = 1'b1;
          pend_d = 1'b0;
          if (in_valid || pend_q) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (in_valid) begin
          // Newest value wins; earlier pending value is dropped.
          pend_d     = 1'b1;
          pend_val_d = bin;
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      state_d    = SHIFT;
      work_d     = start_work;
      scratch_d  = '0;
      cnt_d      = CNT_LOAD;
      sat_flag_d = start_over;
    end
  end

  // State and result registers; reset aborts any conversion silently.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      work_q     <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      sat_flag_q <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      bcd_q      <= '0;
      sat_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      sat_flag_q <= sat_flag_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      bcd_q      <= bcd_d;
      sat_q      <= sat_d;
      done_q     <= done_d;
    end
  end

  assign bcd_out = bcd_q;
  assign sat     = sat_q;
  assign done    = done_q;
  assign busy    = (state_q == SHIFT);

endmodule

// File: doc/bin2bcd8.md
# bin2bcd8

Sequential binary-to-BCD converter that sits directly upstream of the 8-digit seven-segment display driver. It accepts a binary score or debug value, converts it with iterative shift-add-3 (double dabble), and presents a stable packed 8-digit BCD word on `bcd_out`. That word wires straight into the display's 32-bit value input, so digits read in decimal rather than hex. A one-deep pending buffer absorbs updates that arrive mid-conversion, so the producer (CPU memory-mapped register, score counter) never stalls.

## Interface
- `WIDTH`, default 32: binary input width.
- `DIGITS`, default 8: BCD digits produced; `bcd_out` width is 4*DIGITS.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: `bin` is a new value to convert this cycle.
- `bin`  in  WIDTH: unsigned binary value.
- `bcd_out`  out  4*DIGITS: packed BCD; digit 0 in [3:0], digit 7 in [31:28]. Registered and held between conversions.
- `sat`  out  1: last completed result was clamped; updates together with `bcd_out`.
- `done`  out  1: one-cycle pulse on the cycle `bcd_out` takes a new value.
- `busy`  out  1: high while a conversion is in progress.

## Operation
- States: IDLE, SHIFT.
- IDLE with `in_valid`:
  - load the working register with `bin`, clamped to MAX_VAL = 10^DIGITS − 1 (99_999_999);
  - latch the clamp flag, clear the BCD scratch, set the shift counter to WIDTH, go to SHIFT.
- SHIFT, each cycle:
  - every scratch nibble ≥ 5 gets +3 (all nibbles in parallel);
  - then {scratch, working} shifts left by 1;
  - the counter decrements.
- Last shift (counter = 1):
  - write the shifted scratch to `bcd_out` and the clamp flag to `sat`, pulse `done`;
  - go to SHIFT again if a new value is available, otherwise IDLE.
- Pending buffer: `in_valid` while in SHIFT stores `bin` in a pending register and sets `pend`. A later `in_valid` overwrites it; newest wins and intermediate values are dropped.
- On the last-shift cycle:
  - `in_valid` that same cycle wins over `pend`; it is started directly and `pend` is cleared;
  - otherwise, if `pend` is set, the pending value is started and `pend` is cleared.
- Clamping uses unsigned compare against MAX_VAL on the full WIDTH bits. The scratch is 4*DIGITS bits, and the clamp guarantees no overflow.
- `bcd_out` never shows partial results; it holds the previous value throughout SHIFT.
- Reset, including mid-conversion:
  - `bcd_out`=0, `sat`=0, `done`=0, `busy`=0;
  - state IDLE, `pend`=0, counter 0;
  - the aborted conversion produces no `done`.

## Timing
- `in_valid` sampled at edge E0 (IDLE). Shifts occur at E1..E_WIDTH. `bcd_out`/`sat` update and `done`=1 after E_WIDTH, which is 32 cycles for WIDTH=32.
- `busy` is high from after E0 through the cycle ending at E_WIDTH. On back-to-back restart it stays high with no gap.
- Throughput: one conversion per WIDTH cycles. Restart has no idle bubble.
- `done` is never high on two consecutive cycles when WIDTH > 1.

## Structure
- Package `bcd_pkg`:
  - state enum (IDLE, SHIFT);
  - `DIGITS` default;
  - function returning MAX_VAL for a digit count.
- Sub-module `bcd_adjust`: combinational add-3-if-≥5 over a packed DIGITS-nibble vector. It is instantiated once in the SHIFT datapath.
- Top instantiates `bin2bcd8` feeding the display driver's value input.

## Test plan
- Reset, then `bin`=12_345_678 with `in_valid` → after 32 cycles `bcd_out`=32'h12345678, `done` high exactly one cycle, `sat`=0.
- `bin`=0 → 32'h00000000; `bin`=99_999_999 → 32'h99999999, `sat`=0.
- `bin`=32'hFFFFFFFF → 32'h99999999, `sat`=1; then `bin`=5 → 32'h00000005, `sat`=0.
- Convert 42, then during its SHIFT send 7, then 9 → `bcd_out` 32'h00000042 then 32'h00000009; 7 never appears; two `done` pulses; `busy` continuous.
- `in_valid` with 3 on the last-shift cycle while `pend` holds 8 → next result 32'h00000003, `pend` cleared, no third conversion.
- Assert `reset` at cycle 10 of a conversion of 555 → all outputs 0, no `done`. A subsequent convert of 555 → 32'h00000555.
